// File: rtl/deser_multimode.sv
// deser_multimode: ready/valid deserializer that gathers SER_WIDTH-bit serial
// words into one wide parallel word. Each mode has its own words-per-group
// count; the mode is captured on the first word of a group, last_in ends a
// group early, and the final word passes straight through (zero latency).

module deser_multimode #(
   parameter int SER_WIDTH = 32'd16,
   parameter int NUM_MODES = 32'd4,
   parameter int COUNT_MAX = 32'd4,
   parameter int COUNTS [NUM_MODES] = '{32'd1, 32'd2, 32'd3, 32'd4},
   parameter int MSEL_W = (NUM_MODES > 1) ? $clog2(NUM_MODES) : 1,
   parameter int CNT_W = $clog2(COUNT_MAX + 1)
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [MSEL_W-1:0]              mode_sel,
   input  logic [SER_WIDTH-1:0]           serial_in,
   input  logic                           last_in,
   input  logic                           valid_in,
   output logic                           ready_out,
   output logic [SER_WIDTH*COUNT_MAX-1:0] parallel_out,
   output logic [CNT_W-1:0]               word_cnt,
   output logic [MSEL_W-1:0]              mode_out,
   output logic                           valid_out,
   input  logic                           ready_in
);

   localparam int POS_W = (COUNT_MAX > 1) ? $clog2(COUNT_MAX) : 1;

   logic [POS_W-1:0]     pos_s;
   logic [MSEL_W-1:0]    cur_mode_s;
   logic [MSEL_W-1:0]    req_mode_s;
   logic [MSEL_W-1:0]    eff_mode_s;
   logic [SER_WIDTH-1:0] regf_s [COUNT_MAX];
   logic                 last_pos_s;
   logic                 final_s;
   logic                 accept_s;
   logic                 final_hs_s;

   // Words per group for a (legal) mode index.
   function automatic logic [CNT_W-1:0] count_of(input logic [MSEL_W-1:0] m);
      count_of = CNT_W'(COUNTS[m]);
   endfunction

   // Unused mode codes fold onto mode 0; only needed when codes are spare.
   generate
      if ((2 ** MSEL_W) > NUM_MODES) begin : g_mode_fold
         assign req_mode_s = (int'(mode_sel) >= NUM_MODES) ? '0 : mode_sel;
      end else begin : g_mode_direct
         assign req_mode_s = mode_sel;
      end
   endgenerate

   // Effective mode: request on the first word, captured mode afterwards.
   always_comb begin
      eff_mode_s = cur_mode_s;
      if (pos_s == '0) begin
         eff_mode_s = req_mode_s;
      end else begin
         eff_mode_s = cur_mode_s;
      end
   end

   assign last_pos_s = (CNT_W'(pos_s) == (count_of(eff_mode_s) - CNT_W'(1)));
   assign final_s    = valid_in & (last_in | last_pos_s);
   assign valid_out  = final_s;
   assign ready_out  = ready_in | ~final_s;
   assign accept_s   = valid_in & ready_out & ~final_s;
   assign final_hs_s = valid_in & ready_in & final_s;
   assign mode_out   = eff_mode_s;

   generate
      if (COUNT_MAX > 1) begin : g_store
         logic [POS_W-1:0]     pos_r;
         logic [MSEL_W-1:0]    cur_mode_r;
         logic [SER_WIDTH-1:0] regf_r [COUNT_MAX-1];

         // Group position and captured mode; reset discards a partial group.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               pos_r      <= '0;
               cur_mode_r <= '0;
            end else if (accept_s) begin
               pos_r <= pos_r + POS_W'(1);
               if (pos_r == '0) begin
                  cur_mode_r <= eff_mode_s;
               end
            end else if (final_hs_s) begin
               pos_r <= '0;
            end
         end

         // Non-final words land in the slot selected by the current position.
         always_ff @(posedge clk) begin
            for (int i = 0; i < COUNT_MAX - 1; i++) begin
               if (accept_s && (pos_r == POS_W'(i))) begin
                  regf_r[i] <= serial_in;
               end
            end
         end

         assign pos_s      = pos_r;
         assign cur_mode_s = cur_mode_r;
         for (genvar g = 0; g < COUNT_MAX - 1; g++) begin : g_view
            assign regf_s[g] = regf_r[g];
         end
         assign regf_s[COUNT_MAX-1] = '0;
      end else begin : g_pass
         assign pos_s      = '0;
         assign cur_mode_s = '0;
         assign regf_s[0]  = '0;
      end
   endgenerate

   // Output assembly: stored words below pos, live word at pos, zeros above.
   always_comb begin
      parallel_out = '0;
      for (int i = 0; i < COUNT_MAX; i++) begin
         if (i < int'(pos_s)) begin
            parallel_out[i*SER_WIDTH +: SER_WIDTH] = regf_s[i];
         end else if (i == int'(pos_s)) begin
            parallel_out[i*SER_WIDTH +: SER_WIDTH] = serial_in;
         end else begin
            parallel_out[i*SER_WIDTH +: SER_WIDTH] = '0;
         end
      end
   end

   // Word count is only meaningful while a group is being emitted.
   always_comb begin
      word_cnt = '0;
      if (final_s) begin
         word_cnt = CNT_W'(pos_s) + CNT_W'(1);
      end else begin
         word_cnt = '0;
      end
   end

   deser_multimode_chk #(
      .NUM_MODES (NUM_MODES),
      .COUNT_MAX (COUNT_MAX),
      .COUNTS    (COUNTS),
      .CNT_W     (CNT_W)
   ) u_chk (
      .clk       (clk),
      .rst       (rst),
      .valid_out (valid_out),
      .ready_out (ready_out),
      .ready_in  (ready_in),
      .word_cnt  (word_cnt)
   );

endmodule

// deser_multimode_chk: parameter legality and handshake consistency checks.
module deser_multimode_chk #(
   parameter int NUM_MODES = 32'd4,
   parameter int COUNT_MAX = 32'd4,
   parameter int COUNTS [NUM_MODES] = '{32'd1, 32'd2, 32'd3, 32'd4},
   parameter int CNT_W = 32'd3
) (
   input logic             clk,
   input logic             rst,
   input logic             valid_out,
   input logic             ready_out,
   input logic             ready_in,
   input logic [CNT_W-1:0] word_cnt
);

   // Parameter ranges and output relationships, checked every active cycle.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert ((NUM_MODES >= 1) && (NUM_MODES <= 8))
            else $error("deser_multimode: NUM_MODES %0d outside 1..8", NUM_MODES);
         for (int m = 0; m < NUM_MODES; m++) begin
            assert ((COUNTS[m] >= 1) && (COUNTS[m] <= COUNT_MAX))
               else $error("deser_multimode: COUNTS[%0d]=%0d outside 1..%0d", m, COUNTS[m], COUNT_MAX);
         end
         assert (ready_out == (ready_in | ~valid_out))
            else $error("deser_multimode: ready_out inconsistent with valid_out/ready_in");
         assert (!valid_out || ((word_cnt != '0) && (int'(word_cnt) <= COUNT_MAX)))
            else $error("deser_multimode: word_cnt out of range while valid_out");
      end
   end

endmodule

// File: tb/tb_deser_multimode.sv
// Directed self-checking bench for deser_multimode with default parameters
// (COUNTS = {1,2,3,4}). Inputs change 1 time unit after the rising edge and
// outputs are compared on the falling edge.

module tb_deser_multimode;

   logic        clk;
   logic        rst;
   logic [1:0]  mode_sel;
   logic [15:0] serial_in;
   logic        last_in;
   logic        valid_in;
   logic        ready_out;
   logic [63:0] parallel_out;
   logic [2:0]  word_cnt;
   logic [1:0]  mode_out;
   logic        valid_out;
   logic        ready_in;

   logic [70:0] obs;
   int          vectors;
   int          miscompares;

   typedef struct packed {
      logic [15:0] d;
      logic [1:0]  m;
      logic        l;
      logic        v;
      logic        ri;
      logic [70:0] x;
   } step_t;

   deser_multimode dut (
      .clk          (clk),
      .rst          (rst),
      .mode_sel     (mode_sel),
      .serial_in    (serial_in),
      .last_in      (last_in),
      .valid_in     (valid_in),
      .ready_out    (ready_out),
      .parallel_out (parallel_out),
      .word_cnt     (word_cnt),
      .mode_out     (mode_out),
      .valid_out    (valid_out),
      .ready_in     (ready_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign obs = {valid_out, ready_out, word_cnt, mode_out, parallel_out};

   function automatic logic [70:0] e(input logic v, input logic r, input logic [2:0] c,
                                     input logic [1:0] m, input logic [63:0] p);
      e = {v, r, c, m, p};
   endfunction

   task automatic apply(input step_t s);
      serial_in = s.d;
      mode_sel  = s.m;
      last_in   = s.l;
      valid_in  = s.v;
      ready_in  = s.ri;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      apply('{16'h0000, 2'd0, 1'b0, 1'b0, 1'b0, 71'd0});
      @(negedge clk);
      vectors++;
      if (obs !== e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)) begin
         miscompares++;
         $display("FAIL reset: got %h expected %h", obs, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      vectors++;
      if (obs !== e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)) begin
         miscompares++;
         $display("FAIL reset_release: got %h expected %h", obs, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0));
      end
      @(posedge clk); #1;
   endtask

   task automatic test_mode3_full();
      step_t st [5];
      st[0] = '{16'h1A1A, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0000_0000_1A1A)};
      st[1] = '{16'h2B2B, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0000_2B2B_1A1A)};
      st[2] = '{16'h3C3C, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_3C3C_2B2B_1A1A)};
      st[3] = '{16'h4D4D, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd4, 2'd3, 64'h4D4D_3C3C_2B2B_1A1A)};
      st[4] = '{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)};
      for (int k = 0; k < 5; k++) begin
         apply(st[k]);
         @(negedge clk);
         vectors++;
         if (obs !== st[k].x) begin
            miscompares++;
            $display("FAIL mode3_full step %0d: got %h expected %h", k, obs, st[k].x);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_backpressure();
      step_t st [7];
      st[0] = '{16'h1111, 2'd1, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd1, 64'h0000_0000_0000_1111)};
      st[1] = '{16'h2222, 2'd1, 1'b0, 1'b1, 1'b0, e(1'b1, 1'b0, 3'd2, 2'd1, 64'h0000_0000_2222_1111)};
      st[2] = '{16'h2222, 2'd1, 1'b0, 1'b1, 1'b0, e(1'b1, 1'b0, 3'd2, 2'd1, 64'h0000_0000_2222_1111)};
      st[3] = '{16'h2222, 2'd1, 1'b0, 1'b1, 1'b0, e(1'b1, 1'b0, 3'd2, 2'd1, 64'h0000_0000_2222_1111)};
      st[4] = '{16'h2222, 2'd1, 1'b0, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd2, 2'd1, 64'h0000_0000_2222_1111)};
      st[5] = '{16'hABCD, 2'd0, 1'b0, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd1, 2'd0, 64'h0000_0000_0000_ABCD)};
      st[6] = '{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)};
      for (int k = 0; k < 7; k++) begin
         apply(st[k]);
         @(negedge clk);
         vectors++;
         if (obs !== st[k].x) begin
            miscompares++;
            $display("FAIL backpressure step %0d: got %h expected %h", k, obs, st[k].x);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_mode_switch();
      step_t st [6];
      st[0] = '{16'h0101, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0000_0000_0101)};
      st[1] = '{16'h0202, 2'd0, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0000_0202_0101)};
      st[2] = '{16'h0303, 2'd0, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0303_0202_0101)};
      st[3] = '{16'h0404, 2'd0, 1'b0, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd4, 2'd3, 64'h0404_0303_0202_0101)};
      st[4] = '{16'h0505, 2'd0, 1'b0, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd1, 2'd0, 64'h0000_0000_0000_0505)};
      st[5] = '{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)};
      for (int k = 0; k < 6; k++) begin
         apply(st[k]);
         @(negedge clk);
         vectors++;
         if (obs !== st[k].x) begin
            miscompares++;
            $display("FAIL mode_switch step %0d: got %h expected %h", k, obs, st[k].x);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_early_last();
      step_t st [6];
      st[0] = '{16'hAAAA, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0000_0000_AAAA)};
      st[1] = '{16'hBBBB, 2'd3, 1'b1, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd2, 2'd3, 64'h0000_0000_BBBB_AAAA)};
      st[2] = '{16'h7777, 2'd2, 1'b1, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd1, 2'd2, 64'h0000_0000_0000_7777)};
      st[3] = '{16'h1212, 2'd1, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd1, 64'h0000_0000_0000_1212)};
      st[4] = '{16'h3434, 2'd1, 1'b1, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd2, 2'd1, 64'h0000_0000_3434_1212)};
      st[5] = '{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)};
      for (int k = 0; k < 6; k++) begin
         apply(st[k]);
         @(negedge clk);
         vectors++;
         if (obs !== st[k].x) begin
            miscompares++;
            $display("FAIL early_last step %0d: got %h expected %h", k, obs, st[k].x);
         end
         @(posedge clk); #1;
      end
   endtask

   task automatic test_back_to_back();
      logic [63:0] acc;
      logic [15:0] d;
      logic [70:0] x;
      int          pulses;
      acc    = 64'h0;
      pulses = 0;
      for (int g = 0; g < 3; g++) begin
         for (int k = 0; k < 3; k++) begin
            d = {8'(g + 1), 8'(k + 1)};
            if (k == 0) acc = 64'h0;
            acc[k*16 +: 16] = d;
            x = (k == 2) ? e(1'b1, 1'b1, 3'd3, 2'd2, acc) : e(1'b0, 1'b1, 3'd0, 2'd2, acc);
            apply('{d, 2'd2, 1'b0, 1'b1, 1'b1, 71'd0});
            @(negedge clk);
            if (valid_out === 1'b1) pulses++;
            vectors++;
            if (obs !== x) begin
               miscompares++;
               $display("FAIL back_to_back group %0d word %0d: got %h expected %h", g, k, obs, x);
            end
            @(posedge clk); #1;
         end
      end
      apply('{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 71'd0});
      vectors++;
      if (pulses !== 3) begin
         miscompares++;
         $display("FAIL back_to_back pulses: got %0d expected 3", pulses);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid();
      step_t st [5];
      apply('{16'h9001, 2'd3, 1'b0, 1'b1, 1'b1, 71'd0});
      @(posedge clk); #1;
      apply('{16'h9002, 2'd3, 1'b0, 1'b1, 1'b1, 71'd0});
      @(posedge clk); #1;
      apply('{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, 71'd0});
      rst = 1'b1;
      @(negedge clk);
      vectors++;
      if (obs !== e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)) begin
         miscompares++;
         $display("FAIL reset_mid during reset: got %h expected %h", obs, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0));
      end
      @(posedge clk); #1;
      rst = 1'b0;
      st[0] = '{16'h5001, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0000_0000_5001)};
      st[1] = '{16'h5002, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_0000_5002_5001)};
      st[2] = '{16'h5003, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd3, 64'h0000_5003_5002_5001)};
      st[3] = '{16'h5004, 2'd3, 1'b0, 1'b1, 1'b1, e(1'b1, 1'b1, 3'd4, 2'd3, 64'h5004_5003_5002_5001)};
      st[4] = '{16'h0000, 2'd0, 1'b0, 1'b0, 1'b1, e(1'b0, 1'b1, 3'd0, 2'd0, 64'h0)};
      for (int k = 0; k < 5; k++) begin
         apply(st[k]);
         @(negedge clk);
         vectors++;
         if (obs !== st[k].x) begin
            miscompares++;
            $display("FAIL reset_mid step %0d: got %h expected %h", k, obs, st[k].x);
         end
         @(posedge clk); #1;
      end
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      rst         = 1'b1;
      mode_sel    = 2'd0;
      serial_in   = 16'h0000;
      last_in     = 1'b0;
      valid_in    = 1'b0;
      ready_in    = 1'b0;
      @(posedge clk); #1;
      test_reset();
      test_mode3_full();
      test_backpressure();
      test_mode_switch();
      test_early_last();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/deser_multimode.md
Name: deser_multimode

Overview:
- Ready/valid deserializer that gathers SER_WIDTH-bit serial words into one wide parallel word. It supports up to NUM_MODES independent word counts.
- Successor to the two-mode shared deserializer. Improvements over it:
  - the mode is captured per group, so mode_sel may change freely between words;
  - early termination via last_in;
  - a word-count output and zero-masking of unused slots.
- Used at NoC network-interface ingress to rebuild AXI beats/headers from narrow flits.

Parameters:
- SER_WIDTH, 16, width of one serial word.
- NUM_MODES, 4, number of selectable modes (1..8).
- COUNT_MAX, 4, largest count among modes; sizes storage (COUNT_MAX-1 registers) and output width.
- COUNTS, '{1,2,3,4}, int array [NUM_MODES]; COUNTS[m] is the words per group in mode m. Each entry is in 1..COUNT_MAX.
- MSEL_W, $clog2(NUM_MODES) (min 1), width of mode_sel.
- CNT_W, $clog2(COUNT_MAX+1), width of word_cnt.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- mode_sel  in  MSEL_W  mode request; sampled only on the first word of a group.
- serial_in  in  SER_WIDTH  serial data.
- last_in  in  1  marks the current word as the final word of the group (early termination).
- valid_in  in  1  serial word valid.
- ready_out  out  1  serial word accepted when valid_in&ready_out.
- parallel_out  out  SER_WIDTH*COUNT_MAX  assembled word; slot i = bits [(i+1)*SER_WIDTH-1 : i*SER_WIDTH]; slot 0 holds the first word received.
- word_cnt  out  CNT_W  number of valid slots in parallel_out (1..COUNT_MAX).
- mode_out  out  MSEL_W  mode of the group being emitted.
- valid_out  out  1  parallel word valid.
- ready_in  in  1  downstream ready.

Behaviour:
- State:
  - binary position counter pos (0..COUNT_MAX-1);
  - mode register cur_mode;
  - storage regs regf[0..COUNT_MAX-2].
- Effective mode:
  - eff_mode = mode_sel when pos==0, otherwise cur_mode.
  - mode_sel >= NUM_MODES is treated as mode 0.
- final = valid_in & (last_in | pos == COUNTS[eff_mode]-1).
- Handshake:
  - valid_out = final.
  - ready_out = ready_in | ~final. Non-final words are always accepted.
  - The final word is never stored. It passes combinationally into slot pos, so latency from the final serial word to valid_out is 0 cycles.
- On an accepted non-final word (valid_in&ready_out&~final):
  - regf[pos] <= serial_in; pos <= pos+1;
  - if pos==0, cur_mode <= eff_mode.
- On a final handshake (valid_in&ready_in&final): pos <= 0. The stored regs are left unchanged.
- final with ~ready_in: nothing changes. Upstream must hold serial_in/last_in stable (standard valid-stickiness).
- Output assembly:
  - slot i = regf[i] for i<pos;
  - slot pos = serial_in;
  - slots > pos = 0.
- word_cnt = pos+1 while valid_out is high, else 0. mode_out = eff_mode.
- COUNTS[m]==1: every word is final (pass-through), pos stays 0.
- last_in on the first word: a single-word group (word_cnt=1) in any mode.
- last_in on the word at COUNTS-1 is redundant and gives identical behaviour.
- Reset values and reset mid-operation:
  - pos=0, cur_mode=0; regf not reset.
  - Outputs after reset: valid_out=0 with valid_in low; ready_out=1.
  - Reset mid-group discards the partial group; the next word starts a new group.
- COUNT_MAX==1: no storage or counter generated; pure pass-through with word_cnt=1.
- Elaboration checks (assert) fail if:
  - any COUNTS entry is outside 1..COUNT_MAX;
  - NUM_MODES is outside 1..8.

Test Plan:
- Mode 3 (count 4), ready_in=1, words A,B,C,D on 4 consecutive cycles → valid_out only on cycle 4 with parallel_out={D,C,B,A}, word_cnt=4, mode_out=3; ready_out=1 throughout.
- Mode 1 (count 2), words 0x1111,0x2222, ready_in=0 for 3 cycles on the second word → valid_out held, ready_out=0, data stable; one transfer when ready_in rises; pos returns to 0.
- Mode 3 group, mode_sel switched to 0 after the first word → group still completes after 4 words with mode_out=3; the next group uses mode 0 (single-word pass-through).
- Mode 3, words 0xAAAA,0xBBBB with last_in on the second → valid_out on word 2, word_cnt=2, slots 2-3 = 0.
- Back-to-back mode 2 groups (3 words each) with no idle cycles → one valid_out every 3 cycles, no dropped or duplicated words.
- Assert rst after 2 of 4 words, release, then send 4 new words → only the new group is emitted, with correct data.
